// File: rtl/nibble_scan_ctrl.sv
// nibble_scan_ctrl: sweeps the nibble-select lane index from a base lane for a
// programmed number of lanes, captures each selected nibble into a single-entry
// output register and streams it out over a valid/ready handshake.
module nibble_scan_ctrl #(
   parameter int unsigned SEL_W = 8,
   parameter int unsigned CNT_W = SEL_W + 1
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [4*(2**SEL_W)-1:0]   in,
   input  logic                      start,
   input  logic [SEL_W-1:0]          base,
   input  logic [CNT_W-1:0]          count,
   output logic [SEL_W-1:0]          sel,
   output logic [3:0]                out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_last,
   output logic                      busy,
   output logic                      done
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;

   localparam logic [CNT_W-1:0] NumLanes = CNT_W'(2**SEL_W);

   logic [1:0]       state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [3:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             capture;
   logic             last_xfer;

   // Next-state: command acceptance, per-lane capture and final-beat drain.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      rem_d     = rem_q;
      data_d    = data_q;
      valid_d   = valid_q;
      last_d    = last_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      // The output register is free when empty or being drained this cycle.
      capture   = (state_q == StRun) && (!valid_q || out_ready);
      last_xfer = valid_q && out_ready && last_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               if (count == '0) begin
                  // Zero-length command completes immediately without a scan.
                  done_d = 1'b1;
               end else begin
                  sel_d   = base;
                  rem_d   = (count > NumLanes) ? NumLanes : count;
                  busy_d  = 1'b1;
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (capture) begin
               data_d  = in[{sel_q, 2'b00} +: 4];
               valid_d = 1'b1;
               last_d  = (rem_q == CNT_W'(1));
               sel_d   = sel_q + SEL_W'(1);
               rem_d   = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (last_xfer) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-low reset; reset drops any pending beat.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= StIdle;
         sel_q   <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign sel       = sel_q;
   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign out_last  = last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_nibble_scan_ctrl.sv
// tb_nibble_scan_ctrl: table-driven and randomized checks of nibble_scan_ctrl
// against a lane-queue reference model.
module tb_nibble_scan_ctrl;

   logic          clk;
   logic          resetn;
   logic [1023:0] in_bus;
   logic          start;
   logic [7:0]    base;
   logic [8:0]    count;
   logic [7:0]    sel;
   logic [3:0]    out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          busy;
   logic          done;

   nibble_scan_ctrl dut (
      .clk       (clk),
      .resetn    (resetn),
      .in        (in_bus),
      .start     (start),
      .base      (base),
      .count     (count),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: a queue of lanes still to be captured plus the visible outputs.
   int         lanes_q[$];
   logic       m_valid = 1'b0;
   logic       m_last  = 1'b0;
   logic       m_busy  = 1'b0;
   logic       m_done  = 1'b0;
   logic [3:0] m_data  = 4'h0;
   logic [7:0] m_sel   = 8'h0;

   int         xfers = 0;
   int         dones = 0;
   logic [3:0] beats_q[$];
   int         in_mode = 0;
   int         ready_mode = 0;
   int         rp = 0;

   typedef struct {
      int base;
      int count;
      int in_mode;
      int ready_mode;
      int exp_beats;
      int exp_sel;
   } vec_t;
   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // 0: lane k holds k[3:0]; 1: lane k holds ~k[3:0]; 2: random.
   task automatic drive_in();
      logic [7:0] kk;
      if (in_mode == 2) begin
         for (int i = 0; i < 32; i++) in_bus[i*32 +: 32] = $urandom;
      end else begin
         for (int k = 0; k < 256; k++) begin
            kk = 8'(k);
            in_bus[k*4 +: 4] = (in_mode == 0) ? kk[3:0] : ~kk[3:0];
         end
      end
   endtask

   // One clock: snapshot inputs, advance model across the edge, compare after it.
   task automatic step();
      logic [1023:0] p_in;
      logic          p_rst, p_start, p_ready, pv, pl;
      logic [7:0]    p_base;
      logic [8:0]    p_count;
      logic [3:0]    pd;
      int            n, lane;
      p_in = in_bus; p_rst = resetn; p_start = start; p_ready = out_ready;
      p_base = base; p_count = count;
      pv = out_valid; pl = out_last; pd = out_data;
      @(posedge clk);
      #1;
      if (!p_rst) begin
         lanes_q.delete();
         m_valid = 0; m_last = 0; m_busy = 0; m_done = 0; m_data = 0; m_sel = 0;
      end else begin
         m_done = 0;
         if (!m_busy) begin
            if (p_start) begin
               if (p_count == 0) begin
                  m_done = 1;
               end else begin
                  n = (p_count > 256) ? 256 : int'(p_count);
                  for (int i = 0; i < n; i++) lanes_q.push_back((int'(p_base) + i) % 256);
                  m_busy = 1;
                  m_sel  = p_base;
               end
            end
         end else if (lanes_q.size() > 0) begin
            if (!m_valid || p_ready) begin
               lane    = lanes_q.pop_front();
               m_data  = p_in[lane*4 +: 4];
               m_valid = 1;
               m_last  = (lanes_q.size() == 0);
               m_sel   = 8'((lane + 1) % 256);
            end
         end else if (m_valid && p_ready) begin
            m_valid = 0; m_last = 0; m_busy = 0; m_done = 1;
         end
      end
      if (p_rst && pv && p_ready) begin
         xfers++;
         beats_q.push_back(pd);
      end
      if (done === 1'b1) dones++;
      if (p_rst && pv && !p_ready) begin
         check("hold_data", {28'b0, out_data}, {28'b0, pd});
         check("hold_last", {31'b0, out_last}, {31'b0, pl});
         check("hold_valid", {31'b0, out_valid}, 32'd1);
      end
      check("sel", {24'b0, sel}, {24'b0, m_sel});
      check("out_data", {28'b0, out_data}, {28'b0, m_data});
      check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      check("out_last", {31'b0, out_last}, {31'b0, m_last});
      check("busy", {31'b0, busy}, {31'b0, m_busy});
      check("done", {31'b0, done}, {31'b0, m_done});
      if (in_mode == 2) drive_in();
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = (rp % 4 == 0) || (rp % 4 == 3);
         default: out_ready = 1'($urandom % 2);
      endcase
      rp++;
   endtask

   int scan_beats;
   int scan_dones;

   task automatic run_scan(input int b, input int c, input int im, input int rm);
      int x0, d0, guard;
      x0 = xfers; d0 = dones;
      beats_q.delete();
      in_mode = im; ready_mode = rm; rp = 0;
      drive_in();
      base = 8'(b); count = 9'(c); start = 1'b1;
      step();
      start = 1'b0;
      guard = 0;
      while (done !== 1'b1 && guard < 3000) begin
         step();
         guard++;
      end
      check("scan_timeout", (guard >= 3000) ? 32'd1 : 32'd0, 32'd0);
      scan_beats = xfers - x0;
      scan_dones = dones - d0;
   endtask

   task automatic check_scan(input int b, input int exp_beats, input int exp_sel, input int im);
      logic [7:0] l8;
      logic [3:0] e;
      check("scan_beats", scan_beats, exp_beats);
      check("scan_dones", scan_dones, 1);
      check("final_sel", {24'b0, sel}, exp_sel);
      if (im != 2 && beats_q.size() == exp_beats) begin
         for (int i = 0; i < exp_beats; i++) begin
            l8 = 8'((b + i) % 256);
            e  = (im == 0) ? l8[3:0] : ~l8[3:0];
            check("beat_data", {28'b0, beats_q[i]}, {28'b0, e});
         end
      end
   endtask

   initial begin
      int x0, d0, guard, b, c, exp_n;

      // base, count, in_mode, ready_mode, beats, final sel
      vecs[0] = '{3,   4,   0, 0, 4,   7};
      vecs[1] = '{254, 4,   1, 1, 4,   2};
      vecs[2] = '{100, 300, 2, 0, 256, 100};
      vecs[3] = '{0,   1,   0, 2, 1,   1};
      vecs[4] = '{255, 2,   1, 2, 2,   1};
      vecs[5] = '{17,  256, 0, 2, 256, 17};
      vecs[6] = '{5,   0,   0, 0, 0,   17};  // zero count leaves sel untouched

      clk = 0; resetn = 0; start = 1; base = 8'hAA; count = 9'd5; out_ready = 1;
      in_mode = 0; drive_in();

      // Reset held with start asserted.
      step();
      step();
      check("rst_sel", {24'b0, sel}, 0);
      check("rst_valid", {31'b0, out_valid}, 0);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_no_done", dones, 0);
      start = 0; resetn = 1;
      step();

      // Table vectors; each start lands in the done cycle of the previous scan.
      foreach (vecs[i]) begin
         run_scan(vecs[i].base, vecs[i].count, vecs[i].in_mode, vecs[i].ready_mode);
         check_scan(vecs[i].base, vecs[i].exp_beats, vecs[i].exp_sel, vecs[i].in_mode);
      end

      // Start pulsed mid-scan is ignored.
      x0 = xfers; d0 = dones;
      in_mode = 0; ready_mode = 0; drive_in();
      base = 8'd40; count = 9'd8; start = 1; step(); start = 0;
      step(); step(); step();
      base = 8'd0; count = 9'd3; start = 1; step(); start = 0;
      guard = 0;
      while (done !== 1'b1 && guard < 100) begin step(); guard++; end
      step(); step(); step();
      check("ign_beats", xfers - x0, 8);
      check("ign_dones", dones - d0, 1);
      check("ign_sel", {24'b0, sel}, 48);

      // Reset after the second beat of a 10-lane scan.
      x0 = xfers; d0 = dones;
      base = 8'd0; count = 9'd10; start = 1; step(); start = 0;
      guard = 0;
      while (xfers - x0 < 2 && guard < 50) begin step(); guard++; end
      resetn = 0; step(); resetn = 1;
      check("mid_rst_valid", {31'b0, out_valid}, 0);
      check("mid_rst_busy", {31'b0, busy}, 0);
      for (int i = 0; i < 5; i++) step();
      check("mid_rst_no_done", dones - d0, 0);
      run_scan(9, 3, 0, 0);
      check_scan(9, 3, 12, 0);

      // Randomized scans against the model.
      for (int r = 0; r < 15; r++) begin
         b = int'($urandom % 256);
         c = ($urandom % 4 == 0) ? 250 + int'($urandom % 60) : int'($urandom % 12);
         exp_n = (c > 256) ? 256 : c;
         run_scan(b, c, 2, 2);
         check("rnd_beats", scan_beats, exp_n);
         check("rnd_dones", scan_dones, 1);
         check("rnd_sel", {24'b0, sel}, (exp_n == 0) ? int'(sel) : (b + exp_n) % 256);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nibble_scan_ctrl.md
Name: nibble_scan_ctrl

Overview:
- Sequencing controller for the 1024-bit / 256-lane nibble select datapath (out = in[sel*4 +: 4]).
- On a start command, sweeps sel from a base lane for a programmed number of lanes, wrapping modulo 256.
- Captures each selected nibble into a single-entry output register.
- Streams the nibbles out on a valid/ready handshake, with last-beat marking and a done pulse.

Parameters:
- SEL_W, 8, lane index width; lane count = 2**SEL_W; in width = 4*2**SEL_W.
- CNT_W, SEL_W+1, count field width; legal range 0..2**SEL_W.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- resetn, input, 1, synchronous active-low reset.
- in, input, 1024, nibble-packed source bus; lane k = in[4k+3:4k].
- start, input, 1, command strobe; sampled only when busy=0.
- base, input, 8, first lane index; latched with start.
- count, input, 9, number of lanes to emit; latched with start; values >256 are clamped to 256.
- sel, output, 8, current lane index driven to the datapath.
- out_data, output, 4, captured nibble.
- out_valid, output, 1, out_data holds a beat.
- out_ready, input, 1, consumer accepts the beat.
- out_last, output, 1, the current beat is the final beat of the scan.
- busy, output, 1, scan in progress; high from the edge after start until done.
- done, output, 1, one-cycle pulse after the last beat transfers, or after a zero-count command.

Behaviour:
- Reset (resetn=0 at an edge):
  - State returns to IDLE.
  - sel=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0.
  - Reset overrides all other inputs, including in the middle of a scan: the pending beat is dropped and no done pulse is issued.
- States are IDLE, RUN, DRAIN.
- IDLE:
  - start=1 with count=0: busy stays 0; done=1 for one cycle on the next edge; no beats are emitted.
  - start=1 with count>0: latch base into sel, latch min(count,256) into remaining, set busy=1, go to RUN.
- RUN:
  - A capture occurs at an edge when (out_valid=0 or out_ready=1).
  - On capture: out_data<=in[sel*4 +: 4] (sampled at that edge), out_valid<=1, out_last<=(remaining==1), sel<=sel+1 mod 256, remaining<=remaining-1.
  - When a capture consumes remaining==1, go to DRAIN.
  - With no capture, sel, out_data, out_valid and out_last all hold.
- DRAIN:
  - Waits for the last beat to transfer (out_valid & out_ready & out_last).
  - On that edge: out_valid<=0, out_last<=0, busy<=0, done<=1 for one cycle, go to IDLE.
- Handshake rules:
  - A transfer is the cycle in which out_valid=1 and out_ready=1.
  - While out_valid=1 and out_ready=0, out_data and out_last must remain stable.
  - out_valid deasserts only when a transfer occurs and no new capture happens on the same edge.
  - In RUN with out_ready held at 1, throughput is one beat per cycle, back to back.
- Latency:
  - start sampled at edge T gives sel=base after T.
  - The first capture is at T+1, so out_valid=1 after T+1.
  - With ready held high: N beats occupy cycles T+1..T+N, and done=1 after edge T+N+1.
- Wrap-around: sel increments from 255 to 0 with no special handling. For example, base=254, count=4 gives lanes 254, 255, 0, 1.
- count=256 from any base emits all 256 lanes exactly once; the scan ends with sel back at base.
- start is ignored while busy=1.
- A start in the same cycle as done=1 is accepted, because the state is already IDLE.
- The in bus may change every cycle. Each beat reflects in at its capture edge, not at the start edge.

Test Plan:
- Reset: hold resetn=0 for 2 cycles with start=1 -> all outputs 0, busy=0, no done pulse.
- Basic scan: in lane k = k[3:0], base=3, count=4, out_ready=1 -> out_data 3,4,5,6 on consecutive cycles; out_last only on the 4th beat; done one cycle later; busy low afterwards.
- Wrap and back-pressure: base=254, count=4, in lane k = ~k[3:0], out_ready toggled 1,0,0,1,... -> beats F^254[3:0] in order for lanes 254,255,0,1; out_data stable during every ready=0 cycle; exactly 4 transfers.
- Zero count and ignored start: count=0 -> done pulse after 1 cycle, no out_valid. Then start a count=8 scan and pulse start again mid-scan -> exactly 8 beats and a single done.
- Clamp and full sweep: count=300, base=100, random in re-driven each cycle, ready=1 -> exactly 256 beats; each beat equals in[sel*4+:4] as sampled at its capture edge; final sel=100.
- Reset mid-scan: assert resetn=0 after the 2nd beat of a count=10 scan -> out_valid=0 and busy=0 after that edge, no done pulse; a new start then scans normally.
